heart_rate_calc: RTL and testbench
==================================

HEART_RATE_CALC -- requirements
Module: heart_rate_calc

Interface
REQ-001 Parameter SAMPLE_RATE, default 1000: filtered-sample rate in Hz; numerator constant NUM = 60*SAMPLE_RATE SHALL fit 16 bits.
REQ-002 Parameter MIN_INTERVAL, default 250: refractory period in sample ticks (caps output at 240 BPM for the default rate).
REQ-003 Parameter MAX_INTERVAL, default 4095: timeout in sample ticks; interval counter width is 12 bits.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sampleTick  input  1  one-clk strobe per filtered sample.
REQ-007 foundPeak  input  1  peak-detector output, a level that may stay high for many clks.
REQ-008 bpm  output  8  last computed heart rate in BPM, held between updates.
REQ-009 bpmStrobe  output  1  one-clk pulse when bpm updates.
REQ-010 noPulse  output  1  high while no valid beat train exists.
REQ-011 busy  output  1  high while the divider runs.

Function
REQ-012 foundPeak SHALL be registered twice; a beat edge is the cycle where the newer copy is 1 and the older is 0.
REQ-013 The interval FSM SHALL have the states WAIT_FIRST and MEASURE.
REQ-014 WAIT_FIRST behaviour: a beat edge clears the counter, moves to MEASURE, and produces no division.
REQ-015 MEASURE behaviour: the counter increments on each sampleTick and saturates at MAX_INTERVAL.
REQ-016 Beat edge in MEASURE with counter < MIN_INTERVAL: the edge SHALL be ignored and the counter SHALL NOT clear.
REQ-017 Beat edge in MEASURE with counter >= MIN_INTERVAL: accept the edge, latch the counter as the interval, clear the counter, and request a division.
REQ-018 Timeout: counter == MAX_INTERVAL in MEASURE SHALL do all of the following:
- return to WAIT_FIRST;
- set bpm to 0 and noPulse to 1;
- clear the averaging history and any pending request;
- pulse bpmStrobe once.
REQ-019 A beat edge and sampleTick in the same clk: the edge is evaluated against the pre-increment counter; the counter then restarts at 0.
REQ-020 Divider: restoring, 16 iterations, computes NUM / divisor with a 16-bit quotient, using the FSM states DIV_IDLE, DIV_RUN, DIV_DONE.
REQ-021 The divisor SHALL never be 0; MIN_INTERVAL >= 1 is enforced by an elaboration check.
REQ-022 Quotient > 255 SHALL clamp bpm to 255.
REQ-023 In DIV_DONE the block SHALL load bpm, pulse bpmStrobe for exactly one clk, clear noPulse, and return to DIV_IDLE.
REQ-024 Latency: for an edge accepted in cycle E with the divider idle, bpmStrobe SHALL be high in cycle E+18 (E+19 with HR_AVERAGE_EN).
REQ-025 An edge accepted while busy SHALL latch into a single pending slot, overwriting any older pending value; the pending division starts the cycle after DIV_DONE.
REQ-026 A timeout during DIV_RUN SHALL abort the divide, with no strobe from the aborted result.
REQ-027 bpm SHALL hold its value between strobes.

Reset
REQ-028 Reset state:
- bpm = 0, bpmStrobe = 0, noPulse = 1, busy = 0;
- FSMs in WAIT_FIRST and DIV_IDLE;
- counter, history, and pending slot cleared.
REQ-029 Reset asserted mid-division SHALL discard the division, and no bpmStrobe SHALL follow.

Configuration
REQ-030 Macro HR_AVERAGE_EN defined: the divisor is the floor of the 14-bit sum of the last 4 accepted intervals divided by 4 (sum >> 2).
- The first accepted interval after WAIT_FIRST fills all 4 history slots.
- The sum updates one clk before the divide starts.
REQ-031 Macro HR_AVERAGE_EN undefined: the divisor is the latched interval, with no history storage.

Verification
(All scenarios use SAMPLE_RATE=1000 with sampleTick high every clk unless stated otherwise.)
REQ-032 Edges every 1000 ticks -> bpm=60 strobed at E+18 (E+19 averaged); noPulse=0 after the first strobe.
REQ-033 Edges every 750 ticks -> bpm=80. Then one extra edge 200 ticks after a beat -> ignored, next edge at 750 still gives 80.
REQ-034 HR_AVERAGE_EN, intervals 1000,1000,1000,500 -> final bpm=68 (60000/875). Without the macro -> 120.
REQ-035 MIN_INTERVAL=100, interval 200 -> quotient 300 -> bpm=255.
REQ-036 No edge for 4095 ticks after a beat -> bpm=0, noPulse=1, one strobe. The next edge gives no strobe; the one after computes normally.
REQ-037 Reset pulsed at E+5 of a division -> no strobe, bpm=0, noPulse=1, busy=0 from the cycle after reset.

Source files
------------

// File: rtl/heart_rate_calc.sv
// heart_rate_calc
//   Converts the spacing between detected heart beats into a rate in BPM.
//   A beat edge is the rising edge of foundPeak after two register stages.
//   An interval FSM (WAIT_FIRST / MEASURE) counts sample ticks between
//   accepted edges, applies a refractory period and a timeout. A 16-step
//   restoring divider (DIV_IDLE / DIV_RUN / DIV_DONE) then computes
//   60*SAMPLE_RATE / interval, and the result is clamped to 8 bits.
//
// Configuration macro:
//   HR_AVERAGE_EN  when defined, the divisor is the mean of the last four
//                  accepted intervals (floor(sum/4)); otherwise it is the
//                  latest interval.
//
// Ports:
//   clk         system clock (the only clock)
//   reset       synchronous, active-high reset
//   sampleTick  one-clk strobe per filtered sample
//   foundPeak   peak-detector level output
//   bpm         last computed rate, held between updates
//   bpmStrobe   one-clk pulse when bpm updates
//   noPulse     high while no valid beat train exists
//   busy        high while the divider is working
module heart_rate_calc #(
   parameter int SAMPLE_RATE  = 1000,
   parameter int MIN_INTERVAL = 250,
   parameter int MAX_INTERVAL = 4095
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sampleTick,
   input  logic       foundPeak,
   output logic [7:0] bpm,
   output logic       bpmStrobe,
   output logic       noPulse,
   output logic       busy
);

   localparam logic [15:0] NUM   = 16'(60 * SAMPLE_RATE);
   localparam logic [11:0] MIN_L = 12'(MIN_INTERVAL);
   localparam logic [11:0] MAX_L = 12'(MAX_INTERVAL);

   // Parameter sanity: a zero divisor must be impossible.
   if (MIN_INTERVAL < 1) begin : g_min_chk
      $error("heart_rate_calc: MIN_INTERVAL must be at least 1");
   end
   if (MAX_INTERVAL > 4095 || MAX_INTERVAL < MIN_INTERVAL) begin : g_max_chk
      $error("heart_rate_calc: MAX_INTERVAL must lie in MIN_INTERVAL..4095");
   end
   if (60 * SAMPLE_RATE > 65535) begin : g_num_chk
      $error("heart_rate_calc: 60*SAMPLE_RATE must fit 16 bits");
   end

   typedef enum logic {WAIT_FIRST, MEASURE} int_state_t;
   typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

   // Interval side
   int_state_t  int_state;
   logic        pk_new;
   logic        pk_old;
   logic [11:0] cnt;
   logic        beat_edge;
   logic        timeout;
   logic        accept;
   logic        iv_ready;
   logic [11:0] iv_val;

`ifdef HR_AVERAGE_EN
   // Three stored intervals; the newly accepted interval is the fourth slot.
   logic [11:0] hist0;
   logic [11:0] hist1;
   logic [11:0] hist2;
   logic [13:0] sum;
   logic        fill;
   logic        avg_req;
`endif

   // Divider side
   div_state_t  div_state;
   logic [15:0] dq;
   logic [11:0] drem;
   logic [11:0] dvs;
   logic [3:0]  iter;
   logic        pend_valid;
   logic [11:0] pend_val;
   logic [12:0] rem_sh;
   logic        rem_ge;
   logic [11:0] rem_next;
   logic        start_go;
   logic [11:0] start_val;
   logic [7:0]  bpm_clamped;

   // Edge detect, refractory and timeout qualification.
   always_comb begin
      beat_edge = pk_new & ~pk_old;
      timeout   = (int_state == MEASURE) && (cnt == MAX_L);
      // Compared against the pre-increment count, even with a tick this clk.
      accept    = (int_state == MEASURE) && beat_edge && !timeout && (cnt >= MIN_L);
   end

`ifdef HR_AVERAGE_EN
   // The division request follows the sum update by one clk.
   always_comb begin
      iv_ready = avg_req;
      iv_val   = 12'(sum >> 2);
   end
`else
   // The latched interval goes straight to the divider.
   always_comb begin
      iv_ready = accept;
      iv_val   = cnt;
   end
`endif

   // Interval FSM: peak synchroniser, tick counter and optional history.
   always_ff @(posedge clk) begin
      if (reset) begin
         pk_new    <= 1'b0;
         pk_old    <= 1'b0;
         int_state <= WAIT_FIRST;
         cnt       <= 12'd0;
`ifdef HR_AVERAGE_EN
         hist0     <= 12'd0;
         hist1     <= 12'd0;
         hist2     <= 12'd0;
         sum       <= 14'd0;
         fill      <= 1'b0;
         avg_req   <= 1'b0;
`endif
      end else begin
         pk_new <= foundPeak;
         pk_old <= pk_new;
`ifdef HR_AVERAGE_EN
         avg_req <= 1'b0;
`endif
         case (int_state)
            WAIT_FIRST: begin
               cnt <= 12'd0;
               if (beat_edge) begin
                  int_state <= MEASURE;
`ifdef HR_AVERAGE_EN
                  fill <= 1'b1;
`endif
               end
            end
            MEASURE: begin
               if (timeout) begin
                  int_state <= WAIT_FIRST;
                  cnt       <= 12'd0;
`ifdef HR_AVERAGE_EN
                  hist0 <= 12'd0;
                  hist1 <= 12'd0;
                  hist2 <= 12'd0;
                  sum   <= 14'd0;
                  fill  <= 1'b0;
`endif
               end else if (accept) begin
                  cnt <= 12'd0;
`ifdef HR_AVERAGE_EN
                  avg_req <= 1'b1;
                  fill    <= 1'b0;
                  if (fill) begin
                     // First interval of a train stands in for all four.
                     hist0 <= cnt;
                     hist1 <= cnt;
                     hist2 <= cnt;
                     sum   <= {cnt, 2'b00};
                  end else begin
                     hist0 <= cnt;
                     hist1 <= hist0;
                     hist2 <= hist1;
                     sum   <= 14'(cnt) + 14'(hist0) + 14'(hist1) + 14'(hist2);
                  end
`endif
               end else if (sampleTick && (cnt != MAX_L)) begin
                  cnt <= cnt + 12'd1;
               end
            end
            default: begin
               int_state <= WAIT_FIRST;
               cnt       <= 12'd0;
            end
         endcase
      end
   end

   // Divider datapath step, start selection and output clamp.
   always_comb begin
      rem_sh   = {drem, dq[15]};
      rem_ge   = (rem_sh >= {1'b0, dvs});
      rem_next = rem_ge ? 12'(rem_sh - {1'b0, dvs}) : rem_sh[11:0];
      // A fresh interval supersedes an older pending one.
      start_go  = iv_ready | pend_valid;
      start_val = iv_ready ? iv_val : pend_val;
      bpm_clamped = (dq[15:8] != 8'd0) ? 8'hFF : dq[7:0];
   end

   // Divider FSM with pending slot and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_state  <= DIV_IDLE;
         dq         <= 16'd0;
         drem       <= 12'd0;
         dvs        <= 12'd1;
         iter       <= 4'd0;
         pend_valid <= 1'b0;
         pend_val   <= 12'd0;
         bpm        <= 8'd0;
         bpmStrobe  <= 1'b0;
         noPulse    <= 1'b1;
         busy       <= 1'b0;
      end else begin
         bpmStrobe <= 1'b0;
         if (timeout) begin
            // Abort any divide and report loss of pulse.
            div_state  <= DIV_IDLE;
            busy       <= 1'b0;
            pend_valid <= 1'b0;
            bpm        <= 8'd0;
            noPulse    <= 1'b1;
            bpmStrobe  <= 1'b1;
         end else begin
            case (div_state)
               DIV_IDLE: begin
                  if (start_go) begin
                     dvs        <= start_val;
                     dq         <= NUM;
                     drem       <= 12'd0;
                     iter       <= 4'd0;
                     pend_valid <= 1'b0;
                     busy       <= 1'b1;
                     div_state  <= DIV_RUN;
                  end
               end
               DIV_RUN: begin
                  if (iv_ready) begin
                     pend_valid <= 1'b1;
                     pend_val   <= iv_val;
                  end
                  dq   <= {dq[14:0], rem_ge};
                  drem <= rem_next;
                  iter <= iter + 4'd1;
                  if (iter == 4'd15) begin
                     div_state <= DIV_DONE;
                  end
               end
               DIV_DONE: begin
                  if (iv_ready) begin
                     pend_valid <= 1'b1;
                     pend_val   <= iv_val;
                  end
                  bpm       <= bpm_clamped;
                  bpmStrobe <= 1'b1;
                  noPulse   <= 1'b0;
                  busy      <= 1'b0;
                  div_state <= DIV_IDLE;
               end
               default: begin
                  div_state <= DIV_IDLE;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_heart_rate_calc.sv
module tb_heart_rate_calc;

`ifdef HR_AVERAGE_EN
   localparam int LAT    = 19;
   localparam int BPM_34 = 68;
`else
   localparam int LAT    = 18;
   localparam int BPM_34 = 120;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       sampleTick;
   logic       foundPeak;
   logic [7:0] bpm;
   logic       bpmStrobe;
   logic       noPulse;
   logic       busy;

   logic       peak_b;
   logic [7:0] bpm_b;
   logic       strobe_b;
   logic       nopulse_b;
   logic       busy_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int strobe_cnt = 0;
   int last_strobe_cyc = 0;
   int last_bpm = 0;
   int strobe_cnt_b = 0;
   int sc0 = 0;
   int drive_cyc = 0;
   int ref_cyc = 0;
   int db = 0;

   heart_rate_calc dut (
      .clk(clk), .reset(reset), .sampleTick(sampleTick), .foundPeak(foundPeak),
      .bpm(bpm), .bpmStrobe(bpmStrobe), .noPulse(noPulse), .busy(busy)
   );

   heart_rate_calc #(.MIN_INTERVAL(100)) dut_b (
      .clk(clk), .reset(reset), .sampleTick(sampleTick), .foundPeak(peak_b),
      .bpm(bpm_b), .bpmStrobe(strobe_b), .noPulse(nopulse_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bpmStrobe === 1'b1) begin
         strobe_cnt      = strobe_cnt + 1;
         last_strobe_cyc = cyc;
         last_bpm        = int'(bpm);
      end
      if (strobe_b === 1'b1) strobe_cnt_b = strobe_cnt_b + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_bpm", 32'(bpm), 32'd0);
      chk("rst_strobe", 32'(bpmStrobe), 32'd0);
      chk("rst_nopulse", 32'(noPulse), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
   endtask

   // Rising foundPeak 'gap' cycles after the reference beat, held 3 clks.
   task automatic drive_beat(input int gap, input bit set_ref);
      while (cyc < ref_cyc + gap) @(negedge clk);
      sc0       = strobe_cnt;
      drive_cyc = cyc;
      if (set_ref) ref_cyc = cyc;
      foundPeak = 1'b1;
      repeat (3) @(negedge clk);
      foundPeak = 1'b0;
   endtask

   task automatic check_strobe(input bit exp_strobe, input int exp_bpm, input string tag);
      while (cyc < drive_cyc + LAT + 6) @(negedge clk);
      if (exp_strobe) begin
         chk({tag, "_count"}, 32'(strobe_cnt - sc0), 32'd1);
         chk({tag, "_latency"}, 32'(last_strobe_cyc - drive_cyc), 32'(LAT + 1));
         chk({tag, "_bpm"}, 32'(last_bpm), 32'(exp_bpm));
         chk({tag, "_bpm_held"}, 32'(bpm), 32'(exp_bpm));
      end else begin
         chk({tag, "_nostrobe"}, 32'(strobe_cnt - sc0), 32'd0);
      end
   endtask

   initial begin
      sampleTick = 1'b1;
      foundPeak  = 1'b0;
      peak_b     = 1'b0;
      do_reset();

      // 1000-tick intervals -> 60 BPM
      drive_beat(0, 1'b1);
      check_strobe(1'b0, 0, "s60_first");
      chk("s60_first_nopulse", 32'(noPulse), 32'd1);
      drive_beat(1001, 1'b1);
      check_strobe(1'b1, 60, "s60_a");
      chk("s60_nopulse", 32'(noPulse), 32'd0);
      drive_beat(1001, 1'b1);
      check_strobe(1'b1, 60, "s60_b");
      drive_beat(1001, 1'b1);
      check_strobe(1'b1, 60, "s60_c");

      // 750-tick intervals -> 80 BPM, early edge ignored
      do_reset();
      drive_beat(0, 1'b1);
      check_strobe(1'b0, 0, "s80_first");
      drive_beat(751, 1'b1);
      check_strobe(1'b1, 80, "s80_a");
      drive_beat(751, 1'b1);
      check_strobe(1'b1, 80, "s80_b");
      drive_beat(201, 1'b0);
      check_strobe(1'b0, 0, "s80_early");
      drive_beat(751, 1'b1);
      check_strobe(1'b1, 80, "s80_after_early");

      // Refractory boundary: 250 accepted (240 BPM), 249 ignored
      do_reset();
      drive_beat(0, 1'b1);
      check_strobe(1'b0, 0, "min_first");
      drive_beat(251, 1'b1);
      check_strobe(1'b1, 240, "min_250");
      drive_beat(250, 1'b0);
      check_strobe(1'b0, 0, "min_249");

      // Intervals 1000,1000,1000,500
      do_reset();
      drive_beat(0, 1'b1);
      check_strobe(1'b0, 0, "avg_first");
      drive_beat(1001, 1'b1);
      check_strobe(1'b1, 60, "avg_1");
      drive_beat(1001, 1'b1);
      check_strobe(1'b1, 60, "avg_2");
      drive_beat(1001, 1'b1);
      check_strobe(1'b1, 60, "avg_3");
      drive_beat(501, 1'b1);
      check_strobe(1'b1, BPM_34, "avg_4");

      // Timeout 4095 ticks after the last beat
      sc0 = strobe_cnt;
      while (cyc < drive_cyc + 4120) @(negedge clk);
      chk("to_count", 32'(strobe_cnt - sc0), 32'd1);
      chk("to_time", 32'(last_strobe_cyc - drive_cyc), 32'd4098);
      chk("to_bpm", 32'(bpm), 32'd0);
      chk("to_nopulse", 32'(noPulse), 32'd1);
      chk("to_busy", 32'(busy), 32'd0);
      drive_beat(4125, 1'b1);
      check_strobe(1'b0, 0, "to_next");
      drive_beat(1001, 1'b1);
      check_strobe(1'b1, 60, "to_recover");
      chk("to_recover_nopulse", 32'(noPulse), 32'd0);

      // Reset at E+5 of a running division
      drive_beat(1001, 1'b1);
      while (cyc < drive_cyc + 6) @(negedge clk);
      chk("rmid_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rmid_busy", 32'(busy), 32'd0);
      chk("rmid_bpm", 32'(bpm), 32'd0);
      chk("rmid_nopulse", 32'(noPulse), 32'd1);
      while (cyc < drive_cyc + LAT + 10) @(negedge clk);
      chk("rmid_nostrobe", 32'(strobe_cnt - sc0), 32'd0);
      chk("rmid_busy_after", 32'(busy), 32'd0);

      // MIN_INTERVAL=100 instance: interval 200 -> 300 clamps to 255
      db = cyc;
      peak_b = 1'b1;
      repeat (3) @(negedge clk);
      peak_b = 1'b0;
      while (cyc < db + 201) @(negedge clk);
      db = cyc;
      peak_b = 1'b1;
      repeat (3) @(negedge clk);
      peak_b = 1'b0;
      while (cyc < db + LAT + 6) @(negedge clk);
      chk("clamp_count", 32'(strobe_cnt_b), 32'd1);
      chk("clamp_bpm", 32'(bpm_b), 32'd255);
      chk("clamp_nopulse", 32'(nopulse_b), 32'd0);
      chk("clamp_busy", 32'(busy_b), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
